// File: rtl/light_decoder_if.sv
// Bus bundle between the lights selector sample point and the light_decoder monitor.
interface light_decoder_if #(
    parameter int unsigned CNT_W = 8
);
    logic [23:0]      light;
    logic             button;
    logic [2:0]       colour;
    logic             colour_valid;
    logic             white;
    logic             pattern_err;
    logic             seq_err;
    logic             err_flag;
    logic [CNT_W-1:0] err_count;

    modport master (
        output light, button,
        input  colour, colour_valid, white, pattern_err, seq_err, err_flag, err_count
    );

    modport slave (
        input  light, button,
        output colour, colour_valid, white, pattern_err, seq_err, err_flag, err_count
    );
endinterface

// File: rtl/light_decoder.sv
// Receive-side monitor for the lights selector: decodes the 24-bit light bus into a
// colour code, checks each step against the button-driven stepping rule, counts errors.
module light_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    light_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_colour;
    logic [2:0]       w_colour_nxt;
    logic             r_valid;
    logic             r_white;
    logic             r_pat;
    logic             r_seq;
    logic             r_flag;
    logic             r_btn_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [2:0]       w_code;
    logic [2:0]       w_step;
    logic [2:0]       w_expected;
    logic             w_legal;
    logic             w_is_white;
    logic             w_white_nxt;
    logic             w_pat_nxt;
    logic             w_seq_nxt;

    function automatic logic byte_ok(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

    // Bus decode and the colour the selector should be showing now
    always_comb begin
        w_legal    = byte_ok(bus.light[23:16]) && byte_ok(bus.light[15:8]) && byte_ok(bus.light[7:0]);
        w_code     = {&bus.light[23:16], &bus.light[15:8], &bus.light[7:0]};
        w_is_white = w_legal && (w_code == 3'b111);
        w_step     = ((r_colour == 3'b110) || (r_colour == 3'b111)) ? 3'b001 : 3'(r_colour + 3'd1);
        w_expected = r_btn_q ? w_step : r_colour;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_colour_nxt = r_colour;
        w_white_nxt  = 1'b0;
        w_pat_nxt    = 1'b0;
        w_seq_nxt    = 1'b0;
        w_cnt_nxt    = r_cnt;

        if (!w_legal) begin
            w_pat_nxt = 1'b1;
            if (r_state == TRACK) w_state_nxt = RESYNC;
        end else if (w_is_white) begin
            w_white_nxt = 1'b1;
            if (r_state == TRACK) w_state_nxt = RESYNC;
        end else begin
            // A wrong colour is still taken so tracking follows the selector
            unique case (r_state)
                TRACK:   w_seq_nxt = (w_code != w_expected);
                default: w_seq_nxt = 1'b0;
            endcase
            w_colour_nxt = w_code;
            w_state_nxt  = TRACK;
        end

        if ((w_pat_nxt || w_seq_nxt) && (r_cnt != {CNT_W{1'b1}}))
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_colour <= 3'b000;
            r_valid  <= 1'b0;
            r_white  <= 1'b0;
            r_pat    <= 1'b0;
            r_seq    <= 1'b0;
            r_flag   <= 1'b0;
            r_btn_q  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_colour <= w_colour_nxt;
            r_valid  <= (w_state_nxt == TRACK);
            r_white  <= w_white_nxt;
            r_pat    <= w_pat_nxt;
            r_seq    <= w_seq_nxt;
            r_flag   <= r_flag | w_pat_nxt | w_seq_nxt;
            r_btn_q  <= bus.button;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.colour       = r_colour;
    assign bus.colour_valid = r_valid;
    assign bus.white        = r_white;
    assign bus.pattern_err  = r_pat;
    assign bus.seq_err      = r_seq;
    assign bus.err_flag     = r_flag;
    assign bus.err_count    = r_cnt;
endmodule

// File: doc/light_decoder.md
# light_decoder

Receive-side companion to the lights selector: samples the 24-bit `light` bus and the `button` input that drives the selector. Decodes the bus back into the 3-bit colour code and checks that each colour step follows the selector's stepping rule. Flags malformed bus patterns and out-of-sequence colours, and keeps a saturating error count. Sits beside the selector in the Ex7 lights subsystem as an on-chip monitor/receiver on the same clock.

## Interface
- `CNT_W`, default 8: width of `err_count`.

- `clk` input 1: rising-edge clock, shared with the selector.
- `rst` input 1: reset; synchronous and active-high.
- `light` input 24: selector output bus, `{R[23:16], G[15:8], B[7:0]}`.
- `button` input 1: the same `button` signal the selector sees.
- `colour` output 3: last accepted colour code.
- `colour_valid` output 1: high while `colour` holds a sequence-tracked value (state TRACK).
- `white` output 1: the last sample was the white pattern 24'hFFFFFF.
- `pattern_err` output 1: one-cycle pulse; the last sample was not a legal pattern.
- `seq_err` output 1: one-cycle pulse; the last sample was a legal colour that broke the stepping rule.
- `err_flag` output 1: sticky; set by any error, cleared only by `rst`.
- `err_count` output CNT_W: saturating count of errors.

## Operation
- **Decode** (combinational on `light`):
  - Each byte must be 8'h00 or 8'hFF; otherwise the sample is illegal.
  - Code bits: bit2 = R byte is FF, bit1 = G byte is FF, bit0 = B byte is FF.
  - Code 3'b111 (24'hFFFFFF) is always treated as white, never as a colour.
  - Code 3'b000 is a legal colour ("off").
- **Stepping function**: next(c) = 3'b001 if c is 3'b110 or 3'b111; otherwise c+1, computed in 3-bit arithmetic.
  - next(3'b000) = 3'b001.
- **Expected colour**: `btn_q` is `button` registered at the previous edge. expected = `btn_q` ? next(`colour`) : `colour`.
- **States**:
  - IDLE (after reset):
    - Legal non-white sample: accept as `colour`, go to TRACK, no check.
    - White: set `white`, stay in IDLE.
    - Illegal: pulse `pattern_err`, stay in IDLE.
  - TRACK:
    - Legal non-white sample equal to expected: accept.
    - Legal non-white sample not equal to expected: pulse `seq_err`, still accept the sample as `colour`, stay in TRACK.
    - White: set `white`, go to RESYNC; `colour` holds.
    - Illegal: pulse `pattern_err`, go to RESYNC; `colour` holds.
  - RESYNC:
    - Behaves as IDLE, except `colour` keeps its last value.
    - The first legal non-white sample is accepted unchecked, because the selector's counter keeps running under the white mask. Then go to TRACK.
- `colour_valid` is 1 only in TRACK.
- `pattern_err` and `seq_err` are mutually exclusive within a cycle.
- **Error count**: `err_count` increments by 1 on either error pulse and saturates at 2^CNT_W-1 without wrapping.
- `err_flag` is set on the same edge as the first error pulse.

## Timing
- Everything is registered. The sample of `light` at edge k appears on all outputs right after edge k (latency of one edge).
- The step check at edge k uses `button` as sampled at edge k-1. This matches the selector's one-cycle registered response to `button`.
- `white`, `pattern_err` and `seq_err` reflect only the latest sample; they are not stretched.
- **Reset**: `rst` high at an edge gives IDLE with `colour`=0, `colour_valid`=0, `white`=0, `pattern_err`=0, `seq_err`=0, `err_flag`=0, `err_count`=0, `btn_q`=0.
  - Reset overrides any simultaneous error or sample.
  - Reset asserted mid-sequence discards tracking. The first sample after `rst` falls is unchecked.
- **Saturated counter**: when `err_count` is at max and another error occurs, the pulse still fires and the count holds.
- **White at the 3'b110 wrap**: handled by the RESYNC rule; no error is raised.

## Test plan
- **Reset and idle start**: `rst`=1 for 2 cycles, then `light`=24'h000000 with `button`=0 → all outputs 0. After the next edge: `colour`=000, `colour_valid`=1.
- **Full stepping cycle**: `light` steps 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, 0000FF, one step per cycle, with `button`=1 → `colour` goes 001…110 then 001. No `seq_err`; `err_count`=0.
- **Hold check**:
  - `button`=0 and `light` held at 00FF00 for 5 cycles → no errors.
  - Then, still with `button`=0, `light`=00FFFF → `seq_err` pulses once, `err_count`=1, `err_flag`=1, `colour`=011.
- **Illegal pattern**: `light`=24'h00FF0F → `pattern_err` pulses for one cycle and `colour` holds. The next sample, 24'hFF0000, is accepted unchecked, giving `colour`=100 and `colour_valid`=1 one edge later.
- **White mask**: alternate `light` between 24'hFFFFFF and a running colour every 5 cycles, with `button`=1 → `white`=1 and `colour_valid`=0 during masked samples. There are zero errors across 700 ns.
- **Saturation and reset**: with `CNT_W`=2, inject 5 sequence errors → `err_count` reads 1,2,3,3,3. Then assert `rst` on the same edge as a 6th error → all outputs 0.
